// File: rtl/plp_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package plp_mem_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant choice between the instruction and data requesters.
// On contention the requester not named in i_last_grant wins.
module mem_arb_pick
  import plp_mem_pkg::*;
(
  input  logic i_inst_req,
  input  logic i_data_req,
  input  gnt_e i_last_grant,
  output logic o_any_c,
  output gnt_e o_grant_c
);

  // single requester wins outright; contention alternates away from history
  always_comb begin
    o_any_c   = i_inst_req | i_data_req;
    o_grant_c = GNT_DATA;
    if (i_inst_req && i_data_req) begin
      o_grant_c = (i_last_grant == GNT_DATA) ? GNT_INST : GNT_DATA;
    end else if (i_inst_req) begin
      o_grant_c = GNT_INST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one wait-stated memory port between instruction fetch and data.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin on
// contention; otherwise data always wins simultaneous requests.
module mem_port_arbiter
  import plp_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  gnt_e                r_grant;
  logic                r_m_en;
  logic                r_m_we;
  logic [DATA_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_i_ack;
  logic                r_d_ack;

  state_e              w_state;
  logic [CNT_W-1:0]    w_cnt;
  gnt_e                w_grant;
  logic                w_m_en;
  logic                w_m_we;
  logic [DATA_W-1:0]   w_m_addr;
  logic [DATA_W-1:0]   w_m_wdata;
  logic [DATA_W-1:0]   w_i_rdata;
  logic [DATA_W-1:0]   w_d_rdata;
  logic                w_i_ack;
  logic                w_d_ack;
  logic                w_any;
  gnt_e                w_pick;
  gnt_e                w_last;

  mem_arb_pick u_pick (
    .i_inst_req   (i_req),
    .i_data_req   (d_req),
    .i_last_grant (w_last),
    .o_any_c      (w_any),
    .o_grant_c    (w_pick)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  gnt_e r_last;

  // most recent grant, consulted by the picker only on contention
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= GNT_DATA;
    end else if (r_state == IDLE && w_any) begin
      r_last <= w_pick;
    end
  end

  assign w_last = r_last;
`else
  // a fixed instruction history makes every contention resolve to data
  assign w_last = GNT_INST;
`endif

  // next-state and next-output decode; everything holds unless changed
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_grant   = r_grant;
    w_m_en    = r_m_en;
    w_m_we    = r_m_we;
    w_m_addr  = r_m_addr;
    w_m_wdata = r_m_wdata;
    w_i_rdata = r_i_rdata;
    w_d_rdata = r_d_rdata;
    w_i_ack   = 1'b0;
    w_d_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant = w_pick;
          w_state = ACCESS;
          w_m_en  = 1'b1;
          w_cnt   = CNT_W'(WAIT_STATES);
          if (w_pick == GNT_INST) begin
            w_m_addr = i_addr;
            w_m_we   = 1'b0;
          end else begin
            w_m_addr  = d_addr;
            w_m_we    = d_we;
            w_m_wdata = d_wdata;
          end
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else begin
          w_m_en  = 1'b0;
          w_state = RESP;
          if (r_grant == GNT_INST) begin
            w_i_rdata = m_rdata;
            w_i_ack   = 1'b1;
          end else begin
            if (!r_m_we) begin
              w_d_rdata = m_rdata;
            end
            w_d_ack = 1'b1;
          end
        end
      end
      RESP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_grant   <= GNT_DATA;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_grant   <= w_grant;
      r_m_en    <= w_m_en;
      r_m_we    <= w_m_we;
      r_m_addr  <= w_m_addr;
      r_m_wdata <= w_m_wdata;
      r_i_rdata <= w_i_rdata;
      r_d_rdata <= w_d_rdata;
      r_i_ack   <= w_i_ack;
      r_d_ack   <= w_d_ack;
    end
  end

  assign i_rdata = r_i_rdata;
  assign i_ack   = r_i_ack;
  assign d_rdata = r_d_rdata;
  assign d_ack   = r_d_ack;
  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter; honours MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  localparam int unsigned WS = 2;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_STATES(WS)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-timeline model: a grant occupies WS+1 strobe cycles then one
  // ack cycle; the port is free again only after that.
  bit          mb;
  int          mp;
  bit          mg;      // 1 = data
  bit          mlast;   // 1 = data
  bit          e_en, e_we, e_iack, e_dack;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  bit          mem_rand;

  task automatic model_step();
    if (rst) begin
      mb = 0; mp = 0; mlast = 1;
      e_en = 0; e_we = 0; e_iack = 0; e_dack = 0;
      e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
    end else if (!mb) begin
      e_iack = 0; e_dack = 0;
      if (i_req || d_req) begin
        if (i_req && d_req) mg = RR_EN ? !mlast : 1'b1;
        else                mg = d_req;
        mlast = mg; mb = 1; mp = 0; e_en = 1;
        if (mg) begin
          e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
        end else begin
          e_addr = i_addr; e_we = 0;
        end
      end
    end else begin
      mp++;
      if (mp == int'(WS) + 1) begin
        e_en = 0;
        if (mg) begin
          if (!e_we) e_drdata = m_rdata;
          e_dack = 1;
        end else begin
          e_irdata = m_rdata;
          e_iack = 1;
        end
      end else if (mp == int'(WS) + 2) begin
        mb = 0; e_iack = 0; e_dack = 0;
      end
    end
  endtask

  // one clock: advance the model at the edge, compare at the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("i_ack",   32'(i_ack),   32'(e_iack));
    chk("d_ack",   32'(d_ack),   32'(e_dack));
    chk("m_en",    32'(m_en),    32'(e_en));
    chk("m_we",    32'(m_we),    32'(e_we));
    chk("m_addr",  m_addr,  e_addr);
    chk("m_wdata", m_wdata, e_wdata);
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    if (mem_rand) m_rdata = $urandom();
  endtask

  // run until the chosen ack appears (dropping that req) or budget expires
  task automatic run_until_ack(input bit data_side, input int budget, output bit seen);
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      cyc();
      if (!data_side && i_ack) begin seen = 1; i_req = 0; end
      if (data_side && d_ack)  begin seen = 1; d_req = 0; end
    end
  endtask

  bit          seen;
  int          n_en, n_ack, got;
  logic [31:0] saved;

  initial begin
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; mem_rand = 1;
    mb = 0; mp = 0; mg = 1; mlast = 1;
    e_en = 0; e_we = 0; e_iack = 0; e_dack = 0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
    cyc(); cyc();
    rst = 0;
    cyc();

    // instruction fetch with a fixed memory word
    mem_rand = 0; m_rdata = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h100;
    n_en = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      if (m_en) n_en++;
      if (i_ack) begin seen = 1; i_req = 0; end
    end
    chk("s1_ack_seen", 32'(seen), 32'd1);
    chk("s1_en_cycles", 32'(n_en), 32'(WS + 1));
    chk("s1_rdata", i_rdata, 32'hDEADBEEF);
    cyc();
    chk("s1_ack_once", 32'(i_ack), 32'd0);
    mem_rand = 1;

    // data write leaves d_rdata alone
    saved = e_drdata;
    d_req = 1; d_we = 1; d_addr = 32'h4; d_wdata = 32'h12345678;
    cyc();
    chk("s2_we", 32'(m_we), 32'd1);
    chk("s2_wdata", m_wdata, 32'h12345678);
    run_until_ack(1'b1, 20, seen);
    chk("s2_ack_seen", 32'(seen), 32'd1);
    chk("s2_rdata_kept", d_rdata, saved);
    cyc();
    chk("s2_ack_once", 32'(d_ack), 32'd0);
    cyc();

    // contention: served requester re-raises once the port is idle again
    d_we = 0; d_addr = 32'h40; i_addr = 32'h200;
    i_req = 1; d_req = 1;
    for (int g = 0; g < 3; g++) begin
      got = 2;
      for (int k = 0; k < 30 && got == 2; k++) begin
        cyc();
        if (i_ack) begin got = 0; i_req = 0; end
        if (d_ack) begin got = 1; d_req = 0; end
      end
      chk($sformatf("s3_grant%0d", g), 32'(got), RR_EN ? ((g == 1) ? 32'd1 : 32'd0) : 32'd1);
      if (g < 2) begin
        cyc();
        if (got == 0) i_req = 1;
        if (got == 1) d_req = 1;
      end
    end
    i_req = 0; d_req = 0;
    repeat (WS + 4) cyc();

    // data read withdrawn mid-access still completes once
    d_req = 1; d_we = 0; d_addr = 32'h80;
    cyc(); cyc();
    d_req = 0;
    n_ack = 0; n_en = 0;
    for (int k = 0; k < int'(WS) + 8; k++) begin
      cyc();
      if (d_ack) n_ack++;
      if (n_ack != 0 && m_en) n_en++;
    end
    chk("s4_acks", 32'(n_ack), 32'd1);
    chk("s4_no_reaccess", 32'(n_en), 32'd0);

    // reset in the second access cycle abandons the fetch
    i_req = 1; i_addr = 32'h300;
    cyc(); cyc();
    rst = 1; i_req = 0;
    cyc();
    chk("s5_en", 32'(m_en), 32'd0);
    chk("s5_addr", m_addr, 32'd0);
    chk("s5_irdata", i_rdata, 32'd0);
    rst = 0;
    n_ack = 0;
    for (int k = 0; k < int'(WS) + 4; k++) begin
      cyc();
      if (i_ack || d_ack) n_ack++;
    end
    chk("s5_no_ack", 32'(n_ack), 32'd0);
    i_req = 1; i_addr = 32'h304;
    run_until_ack(1'b0, 20, seen);
    chk("s5_recover", 32'(seen), 32'd1);
    cyc();

    // random traffic with occasional withdrawals and resets
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (i_ack) i_req = 0;
      else if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1; i_addr = $urandom();
      end
      if (d_ack) d_req = 0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
      end else if (d_req && $urandom_range(0, 49) == 0) begin
        d_req = 0;
      end
    end
    rst = 0; i_req = 0; d_req = 0;
    repeat (WS + 4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
